// File: rtl/loader_pkg.sv
// Shared types and frame constants for the boot-time imem loader.
package loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LEN,
      DATA,
      CSUM,
      DONE,
      ERR
   } loader_state_e;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_LENGTH  = 2'd1,
      ERR_CSUM    = 2'd2,
      ERR_TIMEOUT = 2'd3
   } loader_err_e;

   localparam int LEN_BYTES  = 4;
   localparam int WORD_BYTES = 4;

   function automatic logic is_busy(input loader_state_e s);
      return (s == LEN) || (s == DATA) || (s == CSUM);
   endfunction

endpackage

// File: rtl/loader_word_packer.sv
// Assembles little-endian 32-bit words from a byte stream; o_last flags the byte
// that completes a word and o_word already includes that byte.
module loader_word_packer
   import loader_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_clear,
   input  logic        i_valid,
   input  logic [7:0]  i_data,
   output logic        o_last,
   output logic [31:0] o_word
);

   localparam int IDX_W = $clog2(WORD_BYTES);

   logic [31:0]      r_word;
   logic [IDX_W-1:0] r_idx;

   always_comb begin
      o_word = r_word;
      o_word[{r_idx, 3'b000} +: 8] = i_data;
      o_last = i_valid && (r_idx == IDX_W'(WORD_BYTES - 1));
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_word <= '0;
         r_idx  <= '0;
      end else if (i_clear) begin
         r_word <= '0;
         r_idx  <= '0;
      end else if (i_valid) begin
         r_word <= o_word;
         r_idx  <= r_idx + 1'b1;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a framed program from a byte stream, writes it into imem
// from word 0 and holds the core until a frame ends with a good XOR checksum.
module imem_loader
   import loader_pkg::*;
#(
   parameter int IMEM_DEPTH     = 1024,
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter bit AUTO_START     = 1'b1,
   localparam int ADDR_W        = $clog2(IMEM_DEPTH)
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic              i_s_valid,
   input  logic [7:0]        i_s_data,
   output logic              o_s_ready,
   output logic              o_imem_we,
   output logic [ADDR_W-1:0] o_imem_addr,
   output logic [31:0]       o_imem_wdata,
   output logic              o_core_hold,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_error,
   output logic [1:0]        o_err_code,
   output logic [ADDR_W:0]   o_words_loaded
);

   localparam int            TW     = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

   loader_state_e r_state, w_nxt;
   loader_err_e   r_err, w_err_nxt;

   logic            w_acc, w_pk_vld, w_last, w_wr, w_tmo;
   logic [31:0]     w_word;
   logic [ADDR_W:0] r_n, r_wrx, r_wl;
   logic            r_we;
   logic [31:0]     r_wdata;
   logic [7:0]      r_csum;
   logic [TW-1:0]   r_tcnt;

   assign o_s_ready = is_busy(r_state);
   // start wins over the handshake: a byte offered alongside start is left on the stream
   assign w_acc     = i_s_valid && o_s_ready && !i_start;
   assign w_pk_vld  = w_acc && ((r_state == LEN) || (r_state == DATA));
   assign w_wr      = w_last && (r_state == DATA);
   assign w_tmo     = o_s_ready && !w_acc && (r_tcnt == T_LAST);

   loader_word_packer u_packer (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clear (i_start),
      .i_valid (w_pk_vld),
      .i_data  (i_s_data),
      .o_last  (w_last),
      .o_word  (w_word)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= AUTO_START ? LEN : IDLE;
         r_err   <= ERR_NONE;
      end else begin
         r_state <= w_nxt;
         r_err   <= w_err_nxt;
      end
   end

   always_comb begin
      w_nxt     = r_state;
      w_err_nxt = r_err;
      if (i_start) begin
         w_nxt     = LEN;
         w_err_nxt = ERR_NONE;
      end else if (w_tmo) begin
         w_nxt     = ERR;
         w_err_nxt = ERR_TIMEOUT;
      end else begin
         case (r_state)
            LEN: if (w_last) begin
               if (w_word > 32'(IMEM_DEPTH)) begin
                  w_nxt     = ERR;
                  w_err_nxt = ERR_LENGTH;
               end else if (w_word == '0) begin
                  w_nxt = CSUM;
               end else begin
                  w_nxt = DATA;
               end
            end
            DATA: if (w_last && (r_wrx == r_n - (ADDR_W+1)'(1))) w_nxt = CSUM;
            CSUM: if (w_acc) begin
               if (i_s_data == r_csum) begin
                  w_nxt = DONE;
               end else begin
                  w_nxt     = ERR;
                  w_err_nxt = ERR_CSUM;
               end
            end
            default: ;
         endcase
      end
   end

   // r_wrx counts words received (frame end), r_wl counts words written (address)
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_we    <= 1'b0;
         r_wdata <= '0;
         r_n     <= '0;
         r_wrx   <= '0;
         r_wl    <= '0;
         r_csum  <= '0;
      end else if (i_start) begin
         r_we   <= 1'b0;
         r_n    <= '0;
         r_wrx  <= '0;
         r_wl   <= '0;
         r_csum <= '0;
      end else begin
         r_we <= w_wr;
         if (w_wr) begin
            r_wdata <= w_word;
            r_wrx   <= r_wrx + 1'b1;
         end
         if (w_last && (r_state == LEN)) r_n <= w_word[ADDR_W:0];
         if (w_acc && (r_state == DATA)) r_csum <= r_csum ^ i_s_data;
         if (r_we) r_wl <= r_wl + 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_tcnt <= '0;
      end else if (i_start || w_acc || !o_s_ready || (w_nxt != r_state)) begin
         r_tcnt <= '0;
      end else begin
         r_tcnt <= r_tcnt + 1'b1;
      end
   end

   assign o_imem_we      = r_we;
   assign o_imem_addr    = r_wl[ADDR_W-1:0];
   assign o_imem_wdata   = r_wdata;
   assign o_core_hold    = (r_state != DONE);
   assign o_busy         = o_s_ready;
   assign o_done         = (r_state == DONE);
   assign o_error        = (r_state == ERR);
   assign o_err_code     = r_err;
   assign o_words_loaded = r_wl;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table of framed loads plus directed corner sequences,
// with expected writes and status derived from the frame bytes by a small model.
module tb_imem_loader;

   localparam int DEPTH = 16;
   localparam int TMO   = 16;
   localparam int AW    = $clog2(DEPTH);

   logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, s_valid = 1'b0;
   logic [7:0]    s_data = '0;
   logic          s_ready, imem_we, core_hold, busy, done, error;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic [1:0]    err_code;
   logic [AW:0]   words_loaded;

   always #5 clk = ~clk;

   imem_loader #(.IMEM_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .AUTO_START(1'b1)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_s_valid(s_valid), .i_s_data(s_data),
      .o_s_ready(s_ready), .o_imem_we(imem_we), .o_imem_addr(imem_addr),
      .o_imem_wdata(imem_wdata), .o_core_hold(core_hold), .o_busy(busy), .o_done(done),
      .o_error(error), .o_err_code(err_code), .o_words_loaded(words_loaded)
   );

   int          total = 0, bad = 0;
   logic [7:0]  tx[$];
   int          obs_a[$], exp_a[$];
   logic [31:0] obs_d[$], exp_d[$];
   bit          m_done;
   logic [1:0]  m_code;
   int          m_wl;

   always @(negedge clk) if (imem_we) begin
      obs_a.push_back(int'(imem_addr));
      obs_d.push_back(imem_wdata);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
      end
   endtask

   task automatic build(input int n, input bit badc);
      logic [7:0] b, x;
      tx.delete();
      for (int k = 0; k < 4; k++) tx.push_back(8'(n >> (8 * k)));
      if (n <= DEPTH) begin
         x = '0;
         for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            tx.push_back(b);
            x ^= b;
         end
         tx.push_back(badc ? ~x : x);
      end
   endtask

   // Frame semantics straight from the byte list: count, LE words, XOR of payload.
   task automatic model();
      int nn;
      logic [7:0] x;
      exp_a.delete();
      exp_d.delete();
      if ({tx[3], tx[2], tx[1], tx[0]} > 32'(DEPTH)) begin
         m_done = 0; m_code = 2'd1; m_wl = 0;
         return;
      end
      nn = int'({tx[3], tx[2], tx[1], tx[0]});
      x  = '0;
      for (int i = 0; i < nn; i++) begin
         exp_a.push_back(i);
         exp_d.push_back({tx[4*i+7], tx[4*i+6], tx[4*i+5], tx[4*i+4]});
      end
      for (int j = 4; j < 4 + 4 * nn; j++) x ^= tx[j];
      m_done = (tx[4 + 4 * nn] == x);
      m_code = m_done ? 2'd0 : 2'd2;
      m_wl   = nn;
   endtask

   // Offers tx[0..cnt-1]; returns #1 after the accepting edge of the last byte.
   task automatic send(input bit gaps, input int cnt);
      for (int i = 0; i < cnt; i++) begin
         int g = 0;
         forever begin
            @(negedge clk);
            s_data  = tx[i];
            s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (s_valid && s_ready) break;
            g++;
            if (g > 64) begin
               chk("send_stall", 32'(i), 32'hFFFF_FFFF);
               s_valid = 1'b0;
               return;
            end
         end
         @(posedge clk);
         #1;
      end
      s_valid = 1'b0;
   endtask

   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      obs_a.delete();
      obs_d.delete();
      chk("start.hold", 32'(core_hold), 32'd1);
      chk("start.wl_clear", 32'(words_loaded), 32'd0);
   endtask

   task automatic finish(input string nm, input bit ed, input logic [1:0] ec, input int ewl);
      int w = 0;
      while (!(done || error) && w < 40) begin
         @(posedge clk);
         #1;
         w++;
      end
      chk({nm, ".ended"}, 32'(done | error), 32'd1);
      chk({nm, ".done"}, 32'(done), 32'(ed));
      chk({nm, ".error"}, 32'(error), 32'(!ed));
      chk({nm, ".code"}, 32'(err_code), 32'(ec));
      chk({nm, ".hold"}, 32'(core_hold), 32'(!ed));
      chk({nm, ".wl"}, 32'(words_loaded), 32'(ewl));
      chk({nm, ".ready"}, 32'(s_ready), 32'd0);
      chk({nm, ".nwr"}, 32'(obs_a.size()), 32'(exp_a.size()));
      for (int i = 0; i < obs_a.size() && i < exp_a.size(); i++) begin
         chk($sformatf("%s.addr%0d", nm, i), 32'(obs_a[i]), 32'(exp_a[i]));
         chk($sformatf("%s.data%0d", nm, i), obs_d[i], exp_d[i]);
      end
   endtask

   typedef struct {
      int         n;
      bit         badc;
      bit         gaps;
      bit         exp_done;
      logic [1:0] exp_code;
      int         exp_wl;
   } vec_t;

   initial begin
      vec_t vt[$];
      int k;
      vt.push_back('{2,           0, 0, 1, 2'd0, 2});
      vt.push_back('{16,          0, 1, 1, 2'd0, 16});
      vt.push_back('{17,          0, 0, 0, 2'd1, 0});
      vt.push_back('{32'h00010001, 0, 0, 0, 2'd1, 0});
      vt.push_back('{0,           0, 1, 1, 2'd0, 0});
      vt.push_back('{0,           1, 0, 0, 2'd2, 0});
      vt.push_back('{1,           1, 1, 0, 2'd2, 1});
      vt.push_back('{5,           0, 1, 1, 2'd0, 5});

      #12;
      chk("rst.hold", 32'(core_hold), 32'd1);
      chk("rst.we", 32'(imem_we), 32'd0);
      chk("rst.done", 32'(done), 32'd0);
      chk("rst.error", 32'(error), 32'd0);
      chk("rst.code", 32'(err_code), 32'd0);
      chk("rst.wl", 32'(words_loaded), 32'd0);
      chk("rst.busy_autostart", 32'(busy), 32'd1);
      chk("rst.ready", 32'(s_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      // Reference program; XOR of the eight payload bytes is 0xB0
      tx = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
             8'h93, 8'h05, 8'h20, 8'h00, 8'hB0};
      exp_a = '{0, 1};
      exp_d = '{32'h00100513, 32'h00200593};
      send(1'b0, tx.size());
      finish("ref_good", 1'b1, 2'd0, 2);

      do_start();
      tx[12] = 8'h00;
      send(1'b0, tx.size());
      finish("ref_badcsum", 1'b0, 2'd2, 2);

      for (int i = 0; i < vt.size(); i++) begin
         do_start();
         build(vt[i].n, vt[i].badc);
         model();
         send(vt[i].gaps, tx.size());
         finish($sformatf("vec%0d", i), vt[i].exp_done, vt[i].exp_code, vt[i].exp_wl);
      end

      // Stream stalls after 5 payload bytes: error exactly TMO cycles after the last byte
      do_start();
      build(3, 1'b0);
      send(1'b0, 9);
      k = 0;
      for (int c = 1; c <= 3 * TMO; c++) begin
         @(posedge clk);
         #1;
         if (error) begin
            k = c;
            break;
         end
      end
      chk("tmo.cycles", 32'(k), 32'(TMO));
      chk("tmo.code", 32'(err_code), 32'd3);
      chk("tmo.wl", 32'(words_loaded), 32'd1);

      // start mid-DATA with a byte offered: byte dropped, reload from word 0
      do_start();
      build(2, 1'b0);
      send(1'b0, 9);
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = 8'hAA;
      start   = 1'b1;
      @(posedge clk);
      #1;
      start   = 1'b0;
      s_valid = 1'b0;
      chk("abort.wl", 32'(words_loaded), 32'd0);
      chk("abort.code", 32'(err_code), 32'd0);
      chk("abort.busy", 32'(busy), 32'd1);
      obs_a.delete();
      obs_d.delete();
      build(1, 1'b0);
      model();
      send(1'b0, tx.size());
      finish("abort_reload", m_done, m_code, m_wl);

      // Reset while a write strobe is pending
      do_start();
      build(1, 1'b0);
      send(1'b0, 8);
      chk("rstmid.we_pending", 32'(imem_we), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("rstmid.we", 32'(imem_we), 32'd0);
      chk("rstmid.hold", 32'(core_hold), 32'd1);
      chk("rstmid.wl", 32'(words_loaded), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      obs_a.delete();
      obs_d.delete();
      build(3, 1'b0);
      model();
      send(1'b1, tx.size());
      finish("after_rst", m_done, m_code, m_wl);

      for (int r = 0; r < 6; r++) begin
         do_start();
         build(int'($urandom_range(0, DEPTH + 2)), 1'($urandom_range(0, 1)));
         model();
         send(1'($urandom_range(0, 1)), tx.size());
         finish($sformatf("rnd%0d", r), m_done, m_code, m_wl);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
